serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial N-bit adder built around a single instance of the team's one-bit `fulladder` cell (ports a, b, ci, sum, co). It is the sequential stage that consumes the full adder's sum and carry outputs. A carry flip-flop feeds carry-out back as the next carry-in, and a sum shift register collects result bits LSB-first. It trades N cycles of latency for one adder cell and is the datapath add unit for the lab's multi-cycle ALU experiments.

## Interface
- N, default 8, operand and result width in bits; legal range N ≥ 1.
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
- start  input  1  request pulse; sampled on rising clk; accepted only in IDLE or DONE.
- a  input  N  operand A; captured only on the accepting edge.
- b  input  N  operand B; captured only on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  high for exactly one cycle, in DONE.
- sum  output  N  result register.
- cout  output  1  final carry-out.

## Operation
- Internal state:
  - A/B shift registers, N bits each.
  - S sum shift register, N bits.
  - carry flip-flop.
  - bit counter, width clog2(N+1).
  - FSM with states IDLE, RUN, DONE.
- The fulladder instance is driven with a = A[0], b = B[0], ci = carry. No other adder logic is permitted.
- IDLE:
  - busy=0, done=0.
  - On start=1: A←a, B←b, carry←0, cnt←0, go to RUN.
  - On start=0: stay in IDLE. sum and cout hold.
- RUN, on each edge:
  - A, B shift right by one.
  - S shifts right with the fulladder sum entering S[N-1].
  - carry←co.
  - cnt←cnt+1.
  - When cnt reaches N-1, this edge processes the last bit: cout←co, go to DONE.
- DONE:
  - done=1, busy=0.
  - On start=1: accept a new operation exactly as IDLE does (go to RUN). This allows back-to-back adds.
  - On start=0: go to IDLE.
- start in RUN is ignored; it is neither queued nor restarts the operation.
- Changes on a/b after the accepting edge have no effect on the running operation.
- Arithmetic: {cout,sum} = a + b, computed modulo 2^(N+1), with no overflow flag. The carry into bit 0 is always 0.
- The sum output is S directly and shows partial results during RUN. It is defined valid from the edge entering DONE until the next accepted start.
- Reset (any time, including mid-RUN):
  - FSM←IDLE; A, B, S, carry, cnt, cout←0.
  - Outputs are busy=0, done=0, sum=0, cout=0.
  - An in-flight operation is discarded, not resumed.
- Reset has priority over start on the same edge.

## Timing
- Call the accepting edge E0. Bits 0..N-1 are processed on edges E1..EN.
- DONE is entered at EN. done=1 and sum/cout are valid in the cycle following EN. Latency is N+1 edges from the start sample to done.
- busy is high in the cycles after E0 through the cycle before EN's result, i.e. exactly N cycles.
- Back-to-back: start held high continuously gives one result every N+1 cycles.
- N=1: RUN lasts one cycle and DONE follows at E1.
- done, busy, sum, and cout are all registered. No combinational path exists from inputs to outputs.

## Test plan
- N=8, reset asserted then released, no start → busy=0, done=0, sum=0x00, cout=0 held indefinitely.
- a=3, b=5, start for one cycle → done is a single-cycle pulse after the 9th edge counting E0. sum=0x08, cout=0. busy high exactly 8 cycles.
- a=0xFF, b=0x01 → sum=0x00, cout=1. Then a=0xAA, b=0x55 → sum=0xFF, cout=0, confirming the carry clears on load.
- Start pulsed again at E3 and operands changed at E2 of an add 0x0F+0x01 → result still sum=0x10, cout=0, done at the original cycle, and no second done.
- reset pulsed asynchronously (between edges) at mid-RUN of 0x80+0x80 → outputs go to 0 before the next edge. A following add 0x80+0x80 gives sum=0x00, cout=1.
- Exhaustive check at N=2: all 16 (a,b) pairs issued back-to-back with start held high → every {cout,sum}==a+b, and done appears every 3 cycles.

Source files
------------

// File: rtl/serial_adder_if.sv
// Handshake and data bundle for the bit-serial adder: request with operands in,
// status and result out.
interface serial_adder_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;

    modport master (output start, a, b, input busy, done, sum, cout);
    modport slave  (input start, a, b, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one fulladder cell, a carry flop fed back as carry-in,
// and operand/sum shift registers processing one bit per clock, LSB first.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);
    assign sum = a ^ b ^ ci;
    assign co  = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    serial_adder_if.slave  io_bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_s;
    logic          r_carry;
    logic          r_cout;
    logic [CW-1:0] r_cnt;

    logic          w_load;
    logic          w_shift;
    logic          w_last;
    logic          w_fa_sum;
    logic          w_fa_co;
    logic [N-1:0]  w_s_next;

    fulladder u_fa (
        .a   (r_a[0]),
        .b   (r_b[0]),
        .ci  (r_carry),
        .sum (w_fa_sum),
        .co  (w_fa_co)
    );

    // New sum bit enters at the MSB so the LSB-first result lands in place after N shifts.
    generate
        if (N == 1) begin : g_s_one
            assign w_s_next = w_fa_sum;
        end else begin : g_s_many
            assign w_s_next = {w_fa_sum, r_s[N-1:1]};
        end
    endgenerate

    assign w_last = (r_cnt == CW'(N - 1));

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.start) begin
                    w_load       = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_shift = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (io_bus.start) begin
                    w_load       = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_a     <= io_bus.a;
                r_b     <= io_bus.b;
                r_carry <= 1'b0;
                r_cnt   <= '0;
            end else if (w_shift) begin
                r_a     <= r_a >> 1;
                r_b     <= r_b >> 1;
                r_s     <= w_s_next;
                r_carry <= w_fa_co;
                r_cnt   <= r_cnt + CW'(1);
                if (w_last) begin
                    r_cout <= w_fa_co;
                end
            end
        end
    end

    assign io_bus.busy = (r_state == S_RUN);
    assign io_bus.done = (r_state == S_DONE);
    assign io_bus.sum  = r_s;
    assign io_bus.cout = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: directed and random adds at N=8, async reset mid-run,
// and an exhaustive back-to-back sweep at N=2, all against plain a+b.
module tb_serial_adder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.N(8)) if8 ();
    serial_adder_if #(.N(2)) if2 ();

    serial_adder #(.N(8)) dut8 (.clk(clk), .reset(reset), .io_bus(if8));
    serial_adder #(.N(2)) dut2 (.clk(clk), .reset(reset), .io_bus(if2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One add at N=8; optionally re-pulses start at E3 and scrambles operands before E2.
    task automatic add8(input logic [7:0] ta, input logic [7:0] tb_v, input bit disturb, input string tag);
        logic [8:0] expv;
        int lat;
        int busy_cnt;
        expv = {1'b0, ta} + {1'b0, tb_v};
        @(negedge clk);
        if8.start = 1'b1;
        if8.a = ta;
        if8.b = tb_v;
        @(negedge clk);
        if8.start = 1'b0;
        if8.a = 8'($urandom);
        if8.b = 8'($urandom);
        lat = 1;
        busy_cnt = 0;
        while (!if8.done && lat < 30) begin
            if (if8.busy) busy_cnt++;
            if (disturb && lat == 2) begin
                if8.a = 8'h55;
                if8.b = 8'hAA;
            end
            if8.start = (disturb && lat == 3);
            @(negedge clk);
            lat++;
        end
        if8.start = 1'b0;
        check({tag, " latency"}, lat, 9);
        check({tag, " busy_cycles"}, busy_cnt, 8);
        check({tag, " result"}, {if8.cout, if8.sum}, expv);
        $display("add8 %s: a=%02h b=%02h -> cout=%0b sum=%02h (expect %03h) lat=%0d",
                 tag, ta, tb_v, if8.cout, if8.sum, expv, lat);
        @(negedge clk);
        check({tag, " done_one_cycle"}, if8.done, 0);
        if (disturb) begin
            for (int k = 0; k < 3; k++) begin
                check({tag, " no_second_done"}, {if8.busy, if8.done}, 0);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        int cyc;
        if8.start = 1'b0; if8.a = '0; if8.b = '0;
        if2.start = 1'b0; if2.a = '0; if2.b = '0;

        // Reset then idle: everything stays at zero.
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("idle_outputs", {if8.busy, if8.done, if8.cout, if8.sum}, 0);
        end
        $display("idle: busy=%0b done=%0b sum=%02h cout=%0b", if8.busy, if8.done, if8.sum, if8.cout);

        add8(8'h03, 8'h05, 1'b0, "3+5");
        add8(8'hFF, 8'h01, 1'b0, "FF+01");
        add8(8'hAA, 8'h55, 1'b0, "AA+55");
        add8(8'h0F, 8'h01, 1'b1, "0F+01_disturb");
        for (int k = 0; k < 4; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            add8(ra, rb, 1'b0, "random");
        end
        add8(8'hF0, 8'h20, 1'b0, "F0+20");

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'h80; if8.b = 8'h80;
        @(negedge clk);
        if8.start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", if8.busy, 1);
        #1 reset = 1'b1;
        #1;
        check("async_reset_outputs", {if8.busy, if8.done, if8.cout, if8.sum}, 0);
        $display("async reset: busy=%0b done=%0b sum=%02h cout=%0b", if8.busy, if8.done, if8.sum, if8.cout);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("post_reset_idle", {if8.busy, if8.done, if8.cout, if8.sum}, 0);
        add8(8'h80, 8'h80, 1'b0, "80+80_after_reset");

        // Exhaustive N=2 with start held high: one result every 3 cycles.
        @(negedge clk);
        if2.start = 1'b1; if2.a = 2'd0; if2.b = 2'd0;
        for (int idx = 0; idx < 16; idx++) begin
            logic [2:0] expv;
            logic [1:0] ea;
            logic [1:0] eb;
            ea = 2'(idx >> 2);
            eb = 2'(idx);
            expv = {1'b0, ea} + {1'b0, eb};
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!if2.done && cyc < 10);
            check("n2_period", cyc, 3);
            check("n2_result", {if2.cout, if2.sum}, expv);
            $display("n2 %0d+%0d -> cout=%0b sum=%0d (expect %0d) period=%0d",
                     ea, eb, if2.cout, if2.sum, expv, cyc);
            if (idx < 15) begin
                if2.a = 2'((idx + 1) >> 2);
                if2.b = 2'(idx + 1);
            end else begin
                if2.start = 1'b0;
            end
        end
        @(negedge clk);
        check("n2_final_idle", {if2.busy, if2.done}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
